// File: rtl/digin_pulse_monitor_pkg.sv
// Shared constants and event packing for the digital-input pulse monitor.
package digin_pulse_monitor_pkg;

    localparam logic [31:0] ST_SAMPLE  = 32'd99;
    localparam logic [31:0] ST_PROCESS = 32'd102;

    localparam logic [3:0] CFG_ADDR_CTRL = 4'd0;
    localparam logic [3:0] CFG_ADDR_MINW = 4'd1;

    localparam int NUM_CH = 16;
    localparam int EVT_W  = 64;

    localparam int EVT_TS      = 32;
    localparam int EVT_TS_W    = 32;
    localparam int EVT_CH      = 28;
    localparam int EVT_CH_W    = 4;
    localparam int EVT_RISE    = 27;
    localparam int EVT_WIDTH   = 0;
    localparam int EVT_WIDTH_W = 16;

    function automatic logic [EVT_W-1:0] pack_event(
        input logic [31:0] ts,
        input logic [3:0]  ch,
        input logic        rising,
        input logic [15:0] width
    );
        logic [EVT_W-1:0] evt;
        evt                          = '0;
        evt[EVT_TS +: EVT_TS_W]      = ts;
        evt[EVT_CH +: EVT_CH_W]      = ch;
        evt[EVT_RISE]                = rising;
        evt[EVT_WIDTH +: EVT_WIDTH_W] = width;
        return evt;
    endfunction

endpackage

// File: rtl/digin_pulse_monitor_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    // A pop frees the slot a full-FIFO push needs in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/digin_pulse_monitor.sv
// Per-frame sampling, debounce and edge timestamping of 16 digital inputs into an event FIFO.
module digin_pulse_monitor
    import digin_pulse_monitor_pkg::*;
#(
    parameter int MODULE     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic [31:0] main_state,
    input  logic [5:0]  channel,
    input  logic [15:0] digin,
    input  logic [31:0] timestamp,
    input  logic [3:0]  prog_channel,
    input  logic [3:0]  prog_address,
    input  logic [4:0]  prog_module,
    input  logic [31:0] prog_word,
    input  logic        prog_we,
    input  logic        reset_monitor,
    output logic [15:0] digin_level,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [63:0] evt_data,
    output logic [8:0]  evt_count,
    output logic        overflow
);

    logic        w_clear;
    logic        w_sample;
    logic        w_process;
    logic        w_cfg;
    logic [3:0]  w_ch;
    logic        w_unused;

    logic [15:0] r_enable;
    logic [15:0] r_polarity;
    logic [7:0]  r_min_width [NUM_CH];
    logic [15:0] r_sampled;
    logic        r_overflow;

    logic        w_level_arr [NUM_CH];
    logic [7:0]  w_filt_arr  [NUM_CH];
    logic [15:0] w_width_arr [NUM_CH];

    logic        w_sampled_bit;
    logic        w_level_bit;
    logic [8:0]  w_filt_inc;
    logic [15:0] w_width_inc;
    logic        w_commit;
    logic        w_level_next;
    logic [7:0]  w_filt_next;
    logic [15:0] w_width_next;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;

    assign w_clear   = reset || (reset_monitor && main_state == ST_SAMPLE);
    assign w_sample  = (channel == 6'd0) && (main_state == ST_SAMPLE);
    assign w_process = (channel[5:4] == 2'b00) && (main_state == ST_PROCESS);
    assign w_ch      = channel[3:0];
    assign w_cfg     = prog_we && (prog_module == 5'(MODULE));
    assign w_unused  = &{1'b0, prog_word[31:8]};

    // Configuration is deliberately left out of reset so a monitor restart keeps its setup.
    always_ff @(posedge dataclk) begin
        if (w_cfg) begin
            case (prog_address)
                CFG_ADDR_CTRL: begin
                    r_enable[prog_channel]   <= prog_word[0];
                    r_polarity[prog_channel] <= prog_word[1];
                end
                CFG_ADDR_MINW: r_min_width[prog_channel] <= prog_word[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_sampled <= '0;
        end else if (w_sample) begin
            r_sampled <= digin ^ r_polarity;
        end
    end

    assign w_sampled_bit = r_sampled[w_ch];
    assign w_level_bit   = w_level_arr[w_ch];
    assign w_filt_inc    = {1'b0, w_filt_arr[w_ch]} + 9'd1;
    assign w_width_inc   = (w_width_arr[w_ch] == 16'hFFFF) ? 16'hFFFF : w_width_arr[w_ch] + 16'd1;

    // Shared next-state datapath for whichever channel owns the current slot.
    always_comb begin
        w_commit     = 1'b0;
        w_level_next = w_level_bit;
        w_filt_next  = '0;
        w_width_next = w_width_inc;
        if (!r_enable[w_ch]) begin
            w_level_next = 1'b0;
            w_width_next = '0;
        end else if (w_sampled_bit != w_level_bit) begin
            if (w_filt_inc >= {1'b0, r_min_width[w_ch]}) begin
                w_commit     = 1'b1;
                w_level_next = w_sampled_bit;
                w_width_next = '0;
            end else begin
                w_filt_next = w_filt_inc[7:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic        r_level;
            logic [7:0]  r_filt;
            logic [15:0] r_width;

            always_ff @(posedge dataclk) begin
                if (w_clear) begin
                    r_level <= 1'b0;
                    r_filt  <= '0;
                    r_width <= '0;
                end else if (w_process && (w_ch == 4'(gi))) begin
                    r_level <= w_level_next;
                    r_filt  <= w_filt_next;
                    r_width <= w_width_next;
                end
            end

            assign w_level_arr[gi] = r_level;
            assign w_filt_arr[gi]  = r_filt;
            assign w_width_arr[gi] = r_width;
            assign digin_level[gi] = r_level;
        end
    endgenerate

    // The reported width counts the commit frame itself, hence the incremented value.
    assign w_push = w_process && w_commit;
    assign w_pop  = evt_ready && !w_empty;

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (9)
    ) u_evt_fifo (
        .i_clk   (dataclk),
        .i_srst  (w_clear),
        .i_push  (w_push),
        .i_data  (pack_event(timestamp, w_ch, w_sampled_bit, w_width_inc)),
        .i_pop   (evt_ready),
        .o_data  (evt_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (evt_count)
    );

    assign evt_valid = !w_empty;

    always_ff @(posedge dataclk) begin
        if (w_clear) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

endmodule
